button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Front-end conditioning stage that feeds the pulse detector.
- Synchronises a raw, asynchronous, bouncing push-button/line input into the clk domain, then filters it with a saturating stability counter.
- Produces a clean level (level_out) that drives the pulse detector's L input, giving exactly one P pulse per physical press.
- Also reports filter activity and counts rejected bounces for diagnostics.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range >= 2.
- DEBOUNCE_CYCLES, 1000, number of additional consecutive stable FSM samples required to accept a transition; legal range 1 .. 2^CNT_WIDTH.
- CNT_WIDTH, 16, width of the stability counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous input, may bounce.
- glitch_clr  input  1  synchronous clear of glitch_cnt.
- level_out  output  1  debounced level; connects to the pulse detector's L input.
- busy  output  1  high while a candidate transition is being qualified.
- glitch_cnt  output  8  saturating count of aborted transitions.

Behaviour:
- Clock/reset: clk is the only clock. reset is synchronous and active-high, with priority over everything.
- Reset values: all synchroniser flops 0, state STABLE_LO, counter 0, level_out 0, busy 0, glitch_cnt 0.
- Synchroniser: btn_in sampled into stage 1; sync_out is stage SYNC_STAGES. A level present on btn_in at edge e0 appears on sync_out after edge e0+SYNC_STAGES-1. The FSM samples sync_out only, never btn_in.
- FSM states: STABLE_LO, ARM_HI, STABLE_HI, ARM_LO.
- STABLE_LO:
  - sync_out=1 -> ARM_HI, cnt<=0.
  - else stay.
- ARM_HI (evaluated each edge, in this priority):
  - sync_out=0 -> STABLE_LO, glitch event.
  - cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI.
  - else cnt<=cnt+1.
- STABLE_HI / ARM_LO: mirror images of the above, with sync_out polarity inverted.
- Outputs are registered state decodes, with no combinational path from btn_in:
  - level_out = 1 in STABLE_HI or ARM_LO.
  - busy = 1 in ARM_HI or ARM_LO.
- Latency: if the FSM first sees the new value at edge k and sync_out holds it, the state changes at edge k+DEBOUNCE_CYCLES. End to end from btn_in: level_out toggles after edge e0+SYNC_STAGES+DEBOUNCE_CYCLES, provided btn_in is stable from e0.
- Qualification: DEBOUNCE_CYCLES+1 consecutive matching FSM samples are required. A single mismatching sample anywhere aborts the candidate.
- Aborted candidate: level_out unchanged, cnt reset on next arm.
- glitch_cnt:
  - +1 per glitch event, saturates at 255 (no wrap).
  - glitch_clr=1 -> 0 next edge; clr wins over a simultaneous glitch event.
- Counter: cnt only advances in ARM states. cnt never exceeds DEBOUNCE_CYCLES-1, so no overflow for legal parameters.
- DEBOUNCE_CYCLES=1: transition at edge k+1 if the sample still matches.
- Reset mid-operation: reset asserted in any state, including mid-ARM, gives reset values at the next edge. A stale synchroniser value must not produce a level change within SYNC_STAGES edges after reset release.
- Downstream guarantee: level_out never toggles twice within DEBOUNCE_CYCLES+1 cycles, so the pulse detector sees at most one rising level per qualified press.

Test Plan:
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_WIDTH=4.
1. Reset with btn_in=1 held for 5 cycles -> level_out=0, busy=0, glitch_cnt=0 throughout. After release, level_out rises 6 edges after the first post-reset sampling edge.
2. Clean press, btn_in 0->1 before edge e0 and held -> busy=1 after edges e0+2..e0+5, level_out=1 after edge e0+6, busy=0 after e0+6. Through the pulse detector, exactly one P pulse results.
3. Bounce: btn_in=1 sampled at e0..e0+2, then 0 -> busy high after e0+2..e0+4, STABLE_LO after edge e0+5, level_out stays 0, glitch_cnt=1.
4. Release from STABLE_HI, btn_in 1->0 at e0 and held -> level_out=0 after edge e0+6. A 1-cycle high spike during ARM_LO aborts the release, level_out stays 1, glitch_cnt increments.
5. 300 back-to-back 2-cycle bounces -> glitch_cnt saturates at 255. Asserting glitch_clr on the same edge as a glitch event -> glitch_cnt=0.
6. Reset asserted 2 edges into ARM_HI with btn_in held 1 -> next edge: state STABLE_LO, busy=0, cnt=0, level_out=0. After reset release, level_out rises only after a full 6-edge requalification.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button conditioner: SYNC_STAGES-flop synchroniser followed by a four-state
// stability filter that accepts a level only after DEBOUNCE_CYCLES+1 matching samples.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       glitch_clr,
  output logic       level_out,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    ARM_HI    = 2'd1,
    STABLE_HI = 2'd2,
    ARM_LO    = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [7:0]           GLITCH_MAX = 8'd255;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   glitch_evt;
  logic                   level_q, level_d;
  logic                   busy_q, busy_d;
  logic [7:0]             glitch_q, glitch_d;

  // Synchroniser shift chain; only its last stage is visible to the filter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= STABLE_LO;
      cnt_q    <= CNT_ZERO;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  // A mismatching sample in an ARM state beats the qualification check.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    glitch_evt = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (sync_out) begin
          state_d = ARM_HI;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = STABLE_LO;
        end
      end
      ARM_HI: begin
        if (!sync_out) begin
          state_d    = STABLE_LO;
          cnt_d      = CNT_ZERO;
          glitch_evt = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!sync_out) begin
          state_d = ARM_LO;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = STABLE_HI;
        end
      end
      ARM_LO: begin
        if (sync_out) begin
          state_d    = STABLE_HI;
          cnt_d      = CNT_ZERO;
          glitch_evt = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs decode the next state so the registered copies track state_q exactly.
  always_comb begin
    level_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      STABLE_LO: begin
        level_d = 1'b0;
        busy_d  = 1'b0;
      end
      ARM_HI: begin
        level_d = 1'b0;
        busy_d  = 1'b1;
      end
      STABLE_HI: begin
        level_d = 1'b1;
        busy_d  = 1'b0;
      end
      ARM_LO: begin
        level_d = 1'b1;
        busy_d  = 1'b1;
      end
      default: begin
        level_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (glitch_clr) begin
      glitch_d = 8'd0;
    end else if (glitch_evt && (glitch_q != GLITCH_MAX)) begin
      glitch_d = glitch_q + 8'd1;
    end else begin
      glitch_d = glitch_q;
    end
  end

  assign level_out  = level_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed vector table, hand-written corner sequences,
// and random stimulus against a run-length reference model.
module tb_button_debouncer;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b0;
  logic       glitch_clr = 1'b0;
  logic       level_out;
  logic       busy;
  logic [7:0] glitch_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: delay line to the filter, then count consecutive samples
  // that disagree with the accepted level.
  int m_pipe[SYNC];
  int m_level, m_run, m_gcnt;

  typedef struct {
    logic b, c, r;
    int   lvl, bsy, gc;
  } vec_t;
  vec_t vq[$];

  button_debouncer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .glitch_clr(glitch_clr),
    .level_out (level_out),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input logic b, input logic c, input logic r);
    int s;
    int g;
    g = 0;
    if (r) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 0;
      m_level = 0; m_run = 0; m_gcnt = 0;
    end else begin
      s = m_pipe[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = int'(b);
      if (s != m_level) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = 1 - m_level;
          m_run = 0;
        end
      end else begin
        g = (m_run != 0) ? 1 : 0;
        m_run = 0;
      end
      if (c) m_gcnt = 0;
      else if (g == 1 && m_gcnt < 255) m_gcnt++;
    end
  endtask

  task automatic tick(input logic b, input logic c, input logic r);
    btn_in = b; glitch_clr = c; reset = r;
    @(posedge clk);
    model_step(b, c, r);
    #1;
    check("model.level", int'(level_out), m_level);
    check("model.busy", int'(busy), (m_run != 0) ? 1 : 0);
    check("model.glitch", int'(glitch_cnt), m_gcnt);
  endtask

  task automatic add(input logic b, input logic c, input logic r,
                     input int l, input int bs, input int g, input int n);
    vec_t v;
    v.b = b; v.c = c; v.r = r; v.lvl = l; v.bsy = bs; v.gc = g;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  initial begin
    int val;
    int len;
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 0;
    m_level = 0; m_run = 0; m_gcnt = 0;

    // Reset with btn held high, then first qualification from the stale-free pipe.
    add(1'b1, 1'b0, 1'b1, 0, 0, 0, 5);
    add(1'b1, 1'b0, 1'b0, 0, 0, 0, 2);
    add(1'b1, 1'b0, 1'b0, 0, 1, 0, 4);
    add(1'b1, 1'b0, 1'b0, 1, 0, 0, 2);
    // Clean release.
    add(1'b0, 1'b0, 1'b0, 1, 0, 0, 2);
    add(1'b0, 1'b0, 1'b0, 1, 1, 0, 4);
    add(1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
    // Bounce: three high samples then low.
    add(1'b1, 1'b0, 1'b0, 0, 0, 0, 2);
    add(1'b1, 1'b0, 1'b0, 0, 1, 0, 1);
    add(1'b0, 1'b0, 1'b0, 0, 1, 0, 2);
    add(1'b0, 1'b0, 1'b0, 0, 0, 1, 2);
    // Press to STABLE_HI, then a release interrupted by a one-cycle spike.
    add(1'b1, 1'b0, 1'b0, 0, 0, 1, 2);
    add(1'b1, 1'b0, 1'b0, 0, 1, 1, 4);
    add(1'b1, 1'b0, 1'b0, 1, 0, 1, 1);
    add(1'b0, 1'b0, 1'b0, 1, 0, 1, 2);
    add(1'b1, 1'b0, 1'b0, 1, 1, 1, 1);
    add(1'b0, 1'b0, 1'b0, 1, 1, 1, 1);
    add(1'b0, 1'b0, 1'b0, 1, 0, 2, 1);
    add(1'b0, 1'b0, 1'b0, 1, 1, 2, 4);
    add(1'b0, 1'b0, 1'b0, 0, 0, 2, 1);

    @(negedge clk);
    foreach (vq[i]) begin
      tick(vq[i].b, vq[i].c, vq[i].r);
      check($sformatf("tbl[%0d].level", i), int'(level_out), vq[i].lvl);
      check($sformatf("tbl[%0d].busy", i), int'(busy), vq[i].bsy);
      check($sformatf("tbl[%0d].glitch", i), int'(glitch_cnt), vq[i].gc);
    end

    // Saturation of glitch_cnt under 300 short bounces.
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
    end
    check("sat.glitch", int'(glitch_cnt), 255);
    check("sat.level", int'(level_out), 0);
    // Clear lands on the same edge as the abort of this bounce.
    tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
    check("pre_clr.glitch", int'(glitch_cnt), 255);
    check("pre_clr.busy", int'(busy), 1);
    tick(1'b0, 1'b1, 1'b0);
    check("clr_wins.glitch", int'(glitch_cnt), 0);
    tick(1'b0, 1'b0, 1'b0);
    check("post_clr.glitch", int'(glitch_cnt), 0);

    // One glitch, then reset two edges into ARM_HI.
    tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
    check("pre_rst.glitch", int'(glitch_cnt), 1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
    check("mid_arm.busy", int'(busy), 1);
    tick(1'b1, 1'b0, 1'b1);
    check("rst.level", int'(level_out), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.glitch", int'(glitch_cnt), 0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      check($sformatf("requal[%0d].level", i), int'(level_out), 0);
      if (i < 2) check($sformatf("requal[%0d].busy", i), int'(busy), 0);
    end
    tick(1'b1, 1'b0, 1'b0);
    check("requal.done", int'(level_out), 1);

    // Random runs of varying length, occasional clear and reset.
    val = 0;
    for (int i = 0; i < 600; i++) begin
      val = 1 - val;
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        tick(val[0], ($urandom_range(0, 31) == 0), ($urandom_range(0, 199) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
